seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter: n, default 8, meaning operand/result width in bits; n SHALL be >= 2.
REQ-002 Port clk: input, 1 bit, sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n: input, 1 bit, reset that SHALL be asynchronous and active-low.
REQ-004 Port start: input, 1 bit, request to begin a division; sampled on rising clk.
REQ-005 Port a: input, n bits, unsigned dividend; sampled with start.
REQ-006 Port b: input, n bits, unsigned divisor; sampled with start.
REQ-007 Port q: output, n bits, registered unsigned quotient.
REQ-008 Port r: output, n bits, registered unsigned remainder.
REQ-009 Port busy: output, 1 bit, high while an accepted division is iterating.
REQ-010 Port done: output, 1 bit, one-cycle pulse; q, r and dbz are valid while it is high.
REQ-011 Port dbz: output, 1 bit, registered divide-by-zero flag for the last completed operation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, a start sampled high at edge E SHALL capture a and b into internal registers.
REQ-014 Capture at edge E with b != 0: the FSM SHALL go to RUN, clear the iteration count, and clear the partial remainder and quotient shift registers.
REQ-015 Capture at edge E with b == 0: the FSM SHALL go directly to DONE and load q = all ones, r = a, dbz = 1.
REQ-016 In RUN, each edge SHALL perform one restoring step: shift the next dividend bit (MSB first) into the (n+1)-bit partial remainder, trial-subtract b, keep the difference if it is non-negative, and shift the result bit into the quotient.
REQ-017 After exactly n RUN edges (E+1 .. E+n), the edge E+n SHALL load q and r from the final quotient and remainder, clear dbz, and move the FSM to DONE.
REQ-018 busy SHALL be 1 exactly when state = RUN.
REQ-019 done SHALL be 1 exactly when state = DONE; this lasts one cycle, after which the FSM returns to IDLE unless start is sampled high.
REQ-020 Latency: for b != 0, done SHALL be high in the cycle after edge E+n; for b == 0, in the cycle after edge E.
REQ-021 start while in RUN SHALL be ignored; it SHALL not disturb the operation in progress or the captured operands.
REQ-022 start sampled high in DONE SHALL be accepted (back-to-back operation), and done SHALL still pulse for exactly one cycle.
REQ-023 q, r and dbz SHALL change only at completion (REQ-015, REQ-017) or at reset, and SHALL hold their values through IDLE and any later RUN.
REQ-024 Results SHALL satisfy a = q*b + r with r < b for all b != 0, including a < b (q = 0, r = a) and a = 0.
REQ-025 Changes on a and b after capture SHALL have no effect on the operation in progress.

Reset
REQ-026 rst_n low SHALL immediately, without a clock edge, force state = IDLE and clear q, r, busy, done, dbz and all internal registers to 0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028 After rst_n deasserts, the first rising edge with start high SHALL be accepted as in REQ-013.

Verification
REQ-029 n=8, a=100, b=7, start pulsed at edge E -> busy high for 8 cycles; done high in the cycle after E+8 with q=14, r=2, dbz=0.
REQ-030 n=8, cases 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 0/3 -> q=0, r=0; 255/255 -> q=1, r=0; each with done after 8 iterations.
REQ-031 n=8, a=42, b=0 -> done in the cycle after E with q=8'hff, r=42, dbz=1; busy never asserts.
REQ-032 start re-pulsed with new operands mid-RUN -> ignored; original result reported; q and r unchanged until that done.
REQ-033 rst_n pulsed low at iteration 4 -> all outputs 0 asynchronously; no done pulse; a fresh 200/13 then yields q=15, r=5.
REQ-034 start held high continuously with 60/4 then 61/4 -> consecutive done pulses n+1 cycles apart, giving q=15, r=0 then q=15, r=1.

Source files
------------

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: done is high in the cycle after capture edge + n (b != 0), or after the capture edge itself (b == 0).
// Backpressure: none; start is ignored while busy, and is accepted in IDLE or in the DONE cycle (back-to-back).
//
// Ports:
//   clk, rst_n   : clock; asynchronous active-low reset
//   start, a, b  : begin a division of a by b (operands sampled with start)
//   q, r, dbz    : registered quotient, remainder and divide-by-zero flag; change only at completion or reset
//   busy         : high while the division is iterating (state RUN)
//   done         : one-cycle pulse; q, r and dbz are valid while it is high (state DONE)
module seq_div #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] q,
  output logic [n-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int cw = (n > 2) ? $clog2(n) : 1;
  localparam logic [cw-1:0] last_cnt = cw'(n - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [n-1:0]  dvd;     // dividend, shifted left so the next bit is always at the MSB
  logic [n-1:0]  dvs;     // captured divisor
  logic [n-1:0]  rem;     // partial remainder; always < dvs, so n bits are enough to hold it
  logic [n-1:0]  quo;     // quotient bits collected so far
  logic [cw-1:0] cnt;

  logic [n:0]    rem_sh;
  logic [n:0]    diff;
  logic          ge;
  logic [n:0]    rem_nxt;
  logic [n-1:0]  quo_nxt;

  // One restoring step. rem_sh < 2*dvs, so diff[n] is a true sign bit:
  // a non-negative difference is < dvs < 2^n, a negative one wraps above 2^n.
  always_comb begin
    rem_sh  = {rem, dvd[n-1]};
    diff    = rem_sh - {1'b0, dvs};
    ge      = ~diff[n];
    rem_nxt = ge ? diff : rem_sh;
    quo_nxt = {quo[n-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            dvd <= a;
            dvs <= b;
            if (b == '0) begin
              // Divide by zero completes immediately without iterating.
              state <= DONE;
              done  <= 1'b1;
              q     <= '1;
              r     <= a;
              dbz   <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              cnt   <= '0;
              rem   <= '0;
              quo   <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          dvd <= {dvd[n-2:0], 1'b0};
          rem <= rem_nxt[n-1:0];
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == last_cnt) begin
            q     <= quo_nxt;
            r     <= rem_nxt[n-1:0];
            dbz   <= 1'b0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;

  localparam int n = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [n-1:0] q;
  logic [n-1:0] r;
  logic         busy;
  logic         done;
  logic         dbz;

  int tests;
  int fails;

  seq_div #(.n(n)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a division and follow it to done. poke >= 0 re-pulses start with
  // other operands at that many cycles into RUN.
  task automatic run_div(input string tag, input logic [n-1:0] da, input logic [n-1:0] db,
                         input logic [n-1:0] eq, input logic [n-1:0] er, input logic edbz,
                         input int elat, input int poke);
    int k;
    int bc;
    int moved;
    logic [n-1:0] q0;
    logic [n-1:0] r0;
    q0    = q;
    r0    = r;
    a     = da;
    b     = db;
    start = 1'b1;
    tick();                     // capture edge E
    start = 1'b0;
    a     = 8'($urandom);       // operands must no longer matter
    b     = 8'($urandom);
    k     = 0;
    bc    = 0;
    moved = 0;
    while (!done && k < 40) begin
      if (busy) bc++;
      if (busy && (q !== q0 || r !== r0)) moved = 1;
      if (k == poke) begin
        start = 1'b1;
        a     = 8'd5;
        b     = 8'd9;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
    end
    start = 1'b0;
    check({tag, " latency"}, k, elat);
    check({tag, " busy_cycles"}, bc, elat);
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);
    check({tag, " dbz"}, dbz, edbz);
    check({tag, " hold_during_run"}, moved, 0);
    tick();
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " q_held_idle"}, q, eq);
  endtask

  initial begin
    int k;
    int seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    check("rst q", q, 0);
    check("rst r", r, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst dbz", dbz, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_div("100/7",   8'd100, 8'd7,   8'd14,  8'd2,   1'b0, n, -1);
    run_div("255/1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, n, -1);
    run_div("5/9",     8'd5,   8'd9,   8'd0,   8'd5,   1'b0, n, -1);
    run_div("0/3",     8'd0,   8'd3,   8'd0,   8'd0,   1'b0, n, -1);
    run_div("255/255", 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, n, -1);
    run_div("42/0",    8'd42,  8'd0,   8'hff,  8'd42,  1'b1, 0, -1);
    run_div("200/201", 8'd200, 8'd201, 8'd0,   8'd200, 1'b0, n, -1);
    // start re-pulsed with 5/9 mid-RUN must be ignored
    run_div("poke",    8'd100, 8'd7,   8'd14,  8'd2,   1'b0, n, 3);

    // Reset at iteration 4 aborts the operation with no done pulse
    a     = 8'd100;
    b     = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort q", q, 0);
    check("abort r", r, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort dbz", dbz, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen = 1;
      tick();
    end
    check("abort no_done", seen, 0);
    run_div("200/13",  8'd200, 8'd13,  8'd15,  8'd5,   1'b0, n, -1);

    // start held high: 60/4 then 61/4 back-to-back
    a     = 8'd60;
    b     = 8'd4;
    start = 1'b1;
    tick();
    a = 8'd61;
    k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    check("b2b first_latency", k, n);
    check("b2b first q", q, 15);
    check("b2b first r", r, 0);
    tick();
    check("b2b gap done", done, 0);
    check("b2b gap busy", busy, 1);
    k = 1;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    start = 1'b0;
    check("b2b spacing", k, n + 1);
    check("b2b second q", q, 15);
    check("b2b second r", r, 1);
    tick();
    check("b2b final done", done, 0);
    check("b2b final busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
